// File: rtl/chan_sel_pkg.sv
// chan_sel_pipe shared types: queue sizing, FSM states, select clamp.
// Optional feature macro: CHAN_SEL_ERR_EN.
package chan_sel_pkg;

  localparam int QDEPTH = 2;
  localparam int CNT_W  = $clog2(QDEPTH + 1);
  localparam int PTR_W  = $clog2(QDEPTH);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [PTR_W-1:0] ptr_t;

  typedef enum logic [CNT_W-1:0] {
    Q_EMPTY = 2'd0,
    Q_ONE   = 2'd1,
    Q_FULL  = 2'd2
  } q_state_t;

  function automatic int unsigned sel_clamp(
    input int unsigned sel,
    input int unsigned num_ch
  );
    return (sel >= num_ch) ? num_ch - 1 : sel;
  endfunction

endpackage

// File: rtl/chan_sel_pipe_if.sv
// Handshake bundle between channel sources, chan_sel_pipe and consumer.
// Optional feature macro: CHAN_SEL_ERR_EN.
interface chan_sel_pipe_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 4,
  parameter int SEL_W  = 2
);

  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [SEL_W-1:0]         sel;
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_W-1:0]        out_data;
  logic [SEL_W-1:0]         out_ch;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    output in_data, sel, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  in_data, sel, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );

endinterface

// File: rtl/chan_sel_q2.sv
// Two-entry registered handshake queue; in_ready depends on state only.
// Optional feature macro: CHAN_SEL_ERR_EN (not used here).
module chan_sel_q2
  import chan_sel_pkg::*;
#(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);

  q_state_t     state_q, state_d;
  ptr_t         head_q, tail_q;
  logic [W-1:0] mem [QDEPTH];
  logic         push, pop;

  assign push_ready = (state_q != Q_FULL);
  assign pop_valid  = (state_q != Q_EMPTY);
  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;
  assign pop_data   = mem[head_q];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      Q_EMPTY: if (push) state_d = Q_ONE;
      Q_ONE: begin
        if (push && !pop)      state_d = Q_FULL;
        else if (pop && !push) state_d = Q_EMPTY;
      end
      Q_FULL:  if (pop) state_d = Q_ONE;
      default: state_d = Q_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= Q_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      for (int i = 0; i < QDEPTH; i++) mem[i] <= '0;
    end else begin
      state_q <= state_d;
      if (push) begin
        mem[tail_q] <= push_data;
        tail_q      <= tail_q + 1'b1;
      end
      if (pop) head_q <= head_q + 1'b1;
    end
  end

endmodule

// File: rtl/chan_sel_pipe.sv
// NUM_CH:1 channel selector with out-of-range clamp and 2-entry output queue.
// Optional feature macro: CHAN_SEL_ERR_EN adds sel_err / oor_cnt.
module chan_sel_pipe
  import chan_sel_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 4,
  parameter int SEL_W  = 2
) (
  input  logic            clk,
  input  logic            rst,
  chan_sel_pipe_if.slave  bus
`ifdef CHAN_SEL_ERR_EN
  ,
  output logic            sel_err,
  output logic [7:0]      oor_cnt
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [SEL_W-1:0]  ch;
  } entry_t;

  logic [SEL_W-1:0] ch_eff;
  entry_t           in_e, out_e;

  assign ch_eff     = SEL_W'(sel_clamp(32'(bus.sel), NUM_CH));
  assign in_e.data  = bus.in_data[int'(ch_eff)*DATA_W +: DATA_W];
  assign in_e.ch    = ch_eff;

  chan_sel_q2 #(
    .W($bits(entry_t))
  ) u_q (
    .clk        (clk),
    .rst        (rst),
    .push_valid (bus.in_valid),
    .push_ready (bus.in_ready),
    .push_data  (in_e),
    .pop_valid  (bus.out_valid),
    .pop_ready  (bus.out_ready),
    .pop_data   (out_e)
  );

  assign bus.out_data = out_e.data;
  assign bus.out_ch   = out_e.ch;

`ifdef CHAN_SEL_ERR_EN
  logic acc_oor;

  assign acc_oor = bus.in_valid && bus.in_ready
                && (32'(bus.sel) >= NUM_CH);

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err <= 1'b0;
      oor_cnt <= '0;
    end else if (acc_oor) begin
      sel_err <= 1'b1;
      if (oor_cnt != 8'hFF) oor_cnt <= oor_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_chan_sel_pipe.sv
// Bench for chan_sel_pipe: directed sequences, a clamp table, random vs queue model.
// Optional feature macro: CHAN_SEL_ERR_EN enables error-counter checks.
module tb_chan_sel_pipe;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  chan_sel_pipe_if #(.NUM_CH(4), .DATA_W(4), .SEL_W(2)) b4 ();
  chan_sel_pipe_if #(.NUM_CH(3), .DATA_W(4), .SEL_W(2)) b3 ();

`ifdef CHAN_SEL_ERR_EN
  logic       err4, err3;
  logic [7:0] cnt4, cnt3;
`endif

  chan_sel_pipe #(.NUM_CH(4), .DATA_W(4), .SEL_W(2)) dut4 (
    .clk     (clk),
    .rst     (rst),
    .bus     (b4.slave)
`ifdef CHAN_SEL_ERR_EN
    ,
    .sel_err (err4),
    .oor_cnt (cnt4)
`endif
  );

  chan_sel_pipe #(.NUM_CH(3), .DATA_W(4), .SEL_W(2)) dut3 (
    .clk     (clk),
    .rst     (rst),
    .bus     (b3.slave)
`ifdef CHAN_SEL_ERR_EN
    ,
    .sel_err (err3),
    .oor_cnt (cnt3)
`endif
  );

  typedef struct {
    logic [1:0]  sel;
    logic [11:0] data;
    logic [3:0]  exp_d;
    logic [1:0]  exp_ch;
  } vec_t;

  typedef struct {
    logic [3:0] d;
    logic [1:0] ch;
  } ment_t;

  vec_t  tbl [6];
  ment_t mq [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int unsigned sel, ch, data;
    bit v, r, push, pop;

    tbl[0] = '{2'd0, 12'h987, 4'h7, 2'd0};
    tbl[1] = '{2'd1, 12'h987, 4'h8, 2'd1};
    tbl[2] = '{2'd2, 12'h987, 4'h9, 2'd2};
    tbl[3] = '{2'd3, 12'h987, 4'h9, 2'd2};
    tbl[4] = '{2'd3, 12'h5A3, 4'h5, 2'd2};
    tbl[5] = '{2'd0, 12'h5A3, 4'h3, 2'd0};

    rst = 1'b1;
    b4.in_data = '0; b4.sel = '0; b4.in_valid = 0; b4.out_ready = 0;
    b3.in_data = '0; b3.sel = '0; b3.in_valid = 0; b3.out_ready = 0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_ovld", b4.out_valid, 0);
    chk("rst_irdy", b4.in_ready, 1);
    chk("rst_data", b4.out_data, 0);
    chk("rst_ch", b4.out_ch, 0);

    // single push, one-cycle latency
    b4.in_data = 16'hDCBA; b4.sel = 2; b4.in_valid = 1; b4.out_ready = 1;
    tick();
    b4.in_valid = 0;
    chk("s1_ovld", b4.out_valid, 1);
    chk("s1_data", b4.out_data, 4'hC);
    chk("s1_ch", b4.out_ch, 2);
    tick();
    chk("s1_empty", b4.out_valid, 0);

    // fill while stalled, refill attempt ignored, drain in order
    b4.out_ready = 0; b4.in_valid = 1; b4.sel = 0;
    tick();
    b4.sel = 1;
    tick();
    chk("s2_full_irdy", b4.in_ready, 0);
    chk("s2_head", b4.out_data, 4'hA);
    b4.sel = 2;
    tick();
    chk("s2_hold_irdy", b4.in_ready, 0);
    chk("s2_hold_data", b4.out_data, 4'hA);
    chk("s2_hold_ch", b4.out_ch, 0);
    b4.in_valid = 0; b4.out_ready = 1;
    tick();
    chk("s2_pop1_irdy", b4.in_ready, 1);
    chk("s2_pop1_data", b4.out_data, 4'hB);
    tick();
    chk("s2_drained", b4.out_valid, 0);

    // steady streaming, one word per cycle
    b4.in_valid = 1; b4.out_ready = 1; b4.sel = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("s4_ch", b4.out_ch, i % 4);
      chk("s4_data", b4.out_data, (32'hDCBA >> (4 * (i % 4))) & 32'hF);
      chk("s4_irdy", b4.in_ready, 1);
      b4.sel = 2'((i + 1) % 4);
    end
    b4.in_valid = 0;
    tick();
    chk("s4_end", b4.out_valid, 0);

    // reset while full discards queued words
    b4.out_ready = 0; b4.in_valid = 1; b4.sel = 1;
    tick();
    b4.sel = 3;
    tick();
    chk("s5_full", b4.in_ready, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0; b4.in_valid = 0;
    chk("s5_ovld", b4.out_valid, 0);
    chk("s5_irdy", b4.in_ready, 1);
    chk("s5_data", b4.out_data, 0);
    chk("s5_ch", b4.out_ch, 0);
    b4.out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s5_stay_empty", b4.out_valid, 0);
    end

    // clamp table on the 3-channel instance
    b3.out_ready = 1;
    foreach (tbl[i]) begin
      b3.sel = tbl[i].sel; b3.in_data = tbl[i].data; b3.in_valid = 1;
      tick();
      b3.in_valid = 0;
      chk("tbl_ovld", b3.out_valid, 1);
      chk("tbl_data", b3.out_data, tbl[i].exp_d);
      chk("tbl_ch", b3.out_ch, tbl[i].exp_ch);
      tick();
    end
`ifdef CHAN_SEL_ERR_EN
    chk("err_flag", err3, 1);
    chk("err_cnt", cnt3, 2);
    chk("err4_flag", err4, 0);
    b3.sel = 3; b3.in_valid = 1;
    for (int i = 0; i < 300; i++) tick();
    b3.in_valid = 0;
    tick();
    chk("err_sat", cnt3, 255);
    chk("err_sat_flag", err3, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("err_rst_cnt", cnt3, 0);
    chk("err_rst_flag", err3, 0);
`endif

    // random traffic against a queue model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mq.delete();
    for (int n = 0; n < 400; n++) begin
      chk("rnd_ovld", b4.out_valid, 32'(mq.size() != 0));
      chk("rnd_irdy", b4.in_ready, 32'(mq.size() != 2));
      if (mq.size() != 0) begin
        chk("rnd_data", b4.out_data, mq[0].d);
        chk("rnd_ch", b4.out_ch, mq[0].ch);
      end
      v    = ($urandom_range(0, 3) != 0);
      r    = $urandom_range(0, 1) == 1;
      sel  = $urandom_range(0, 3);
      data = $urandom & 32'hFFFF;
      b4.in_valid = v; b4.out_ready = r;
      b4.sel = 2'(sel); b4.in_data = 16'(data);
      push = v && (mq.size() < 2);
      pop  = r && (mq.size() > 0);
      ch   = (sel >= 4) ? 3 : sel;
      tick();
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back('{4'((data >> (4 * ch)) & 15), 2'(ch)});
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
